// File: rtl/i2c_reg_access.sv
// Expands one register read/write request into the START/WRITE/READ/STOP byte
// command stream for i2c_master; one command outstanding, aborts on NACK.
module i2c_reg_access #(
  parameter int REG_ADDR_BYTES = 1,
  parameter int DATA_BYTES     = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic                      i_req_rnw,
  input  logic [6:0]                i_req_dev_addr,
  input  logic [8*REG_ADDR_BYTES-1:0] i_req_reg_addr,
  input  logic [8*DATA_BYTES-1:0]   i_req_wdata,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [8*DATA_BYTES-1:0]   o_rsp_rdata,
  output logic                      o_rsp_nack,
  output logic                      o_cmd_valid,
  input  logic                      i_cmd_ready,
  output logic [1:0]                o_cmd_op,
  output logic [7:0]                o_cmd_wdata,
  output logic                      o_cmd_rd_nack,
  input  logic                      i_res_valid,
  input  logic [7:0]                i_res_rdata,
  input  logic                      i_res_nack,
  output logic                      o_busy
);
  localparam int RAB = REG_ADDR_BYTES;
  localparam int DB  = DATA_BYTES;
  localparam logic [1:0] OP_START = 2'd0, OP_WRITE = 2'd1, OP_READ = 2'd2, OP_STOP = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR_W, S_REG, S_DATA_W, S_RESTART, S_ADDR_R, S_DATA_R, S_STOP, S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic              pend_q, pend_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              rnw_q, rnw_d;
  logic [6:0]        dev_q, dev_d;
  logic [8*RAB-1:0]  reg_q, reg_d;
  logic [8*DB-1:0]   wdata_q, wdata_d;
  logic [8*DB-1:0]   rdata_q, rdata_d;
  logic              nack_q, nack_d;

  logic              res_seen;
  logic              wr_nack;
  logic              last_reg;
  logic              last_dat;
  logic [8*DB-1:0]   rdata_sh;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    rnw_d   = rnw_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    nack_d  = nack_q;

    o_req_ready   = 1'b0;
    o_rsp_valid   = 1'b0;
    o_rsp_rdata   = '0;
    o_rsp_nack    = 1'b0;
    o_cmd_valid   = 1'b0;
    o_cmd_op      = OP_START;
    o_cmd_wdata   = 8'h00;
    o_cmd_rd_nack = 1'b0;
    o_busy        = (state_q != S_IDLE);

    res_seen = pend_q & i_res_valid;
    wr_nack  = res_seen & i_res_nack;
    last_reg = (cnt_q == 3'(RAB - 1));
    last_dat = (cnt_q == 3'(DB - 1));
    rdata_sh = rdata_q << 8;
    rdata_sh[7:0] = i_res_rdata;

    // Every state between IDLE and RESP issues exactly one command and waits for its result.
    if (state_q != S_IDLE && state_q != S_RESP) begin
      o_cmd_valid = ~pend_q;
      if (o_cmd_valid && i_cmd_ready) pend_d = 1'b1;
      if (res_seen) pend_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          rnw_d   = i_req_rnw;
          dev_d   = i_req_dev_addr;
          reg_d   = i_req_reg_addr;
          wdata_d = i_req_wdata;
          rdata_d = '0;
          nack_d  = 1'b0;
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        o_cmd_op = OP_START;
        if (res_seen) state_d = S_ADDR_W;
      end
      S_ADDR_W: begin
        o_cmd_op    = OP_WRITE;
        o_cmd_wdata = {dev_q, 1'b0};
        if (res_seen) begin
          state_d = S_REG;
          cnt_d   = '0;
        end
      end
      S_REG: begin
        o_cmd_op    = OP_WRITE;
        o_cmd_wdata = reg_q[8*RAB-1 -: 8];
        if (res_seen) begin
          reg_d = reg_q << 8;
          cnt_d = cnt_q + 3'd1;
          if (last_reg) begin
            state_d = rnw_q ? S_RESTART : S_DATA_W;
            cnt_d   = '0;
          end
        end
      end
      S_DATA_W: begin
        o_cmd_op    = OP_WRITE;
        o_cmd_wdata = wdata_q[8*DB-1 -: 8];
        if (res_seen) begin
          wdata_d = wdata_q << 8;
          cnt_d   = cnt_q + 3'd1;
          if (last_dat) state_d = S_STOP;
        end
      end
      S_RESTART: begin
        o_cmd_op = OP_START;
        if (res_seen) state_d = S_ADDR_R;
      end
      S_ADDR_R: begin
        o_cmd_op    = OP_WRITE;
        o_cmd_wdata = {dev_q, 1'b1};
        if (res_seen) begin
          state_d = S_DATA_R;
          cnt_d   = '0;
        end
      end
      S_DATA_R: begin
        o_cmd_op      = OP_READ;
        o_cmd_rd_nack = last_dat;
        if (res_seen) begin
          rdata_d = rdata_sh;
          cnt_d   = cnt_q + 3'd1;
          if (last_dat) state_d = S_STOP;
        end
      end
      S_STOP: begin
        o_cmd_op = OP_STOP;
        if (res_seen) state_d = S_RESP;
      end
      S_RESP: begin
        o_rsp_valid = 1'b1;
        o_rsp_rdata = rdata_q;
        o_rsp_nack  = nack_q;
        if (i_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A NACKed write byte abandons the remaining bytes and closes the bus.
    if (wr_nack && o_cmd_op == OP_WRITE) begin
      state_d = S_STOP;
      nack_d  = 1'b1;
      rdata_d = '0;
    end

    if (!o_cmd_valid) begin
      o_cmd_op      = OP_START;
      o_cmd_wdata   = 8'h00;
      o_cmd_rd_nack = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      rnw_q   <= 1'b0;
      dev_q   <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      rnw_q   <= rnw_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      nack_q  <= nack_d;
    end
  end
endmodule

// File: tb/tb_i2c_reg_access.sv
// Randomized bench for i2c_reg_access (2 reg-address bytes, 2 data bytes) with a
// command-list reference model and an emulated i2c_master.
module tb_i2c_reg_access;
  localparam int RAB = 2;
  localparam int DB  = 2;
  localparam logic [1:0] OP_START = 2'd0, OP_WRITE = 2'd1, OP_READ = 2'd2, OP_STOP = 2'd3;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_rnw;
  logic [6:0]        req_dev;
  logic [8*RAB-1:0]  req_reg;
  logic [8*DB-1:0]   req_wdata;
  logic              rsp_valid, rsp_ready, rsp_nack;
  logic [8*DB-1:0]   rsp_rdata;
  logic              cmd_valid, cmd_ready, cmd_rd_nack;
  logic [1:0]        cmd_op;
  logic [7:0]        cmd_wdata;
  logic              res_valid, res_nack;
  logic [7:0]        res_rdata;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  i2c_reg_access #(.REG_ADDR_BYTES(RAB), .DATA_BYTES(DB)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_rnw(req_rnw),
    .i_req_dev_addr(req_dev), .i_req_reg_addr(req_reg), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata), .o_rsp_nack(rsp_nack),
    .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready), .o_cmd_op(cmd_op),
    .o_cmd_wdata(cmd_wdata), .o_cmd_rd_nack(cmd_rd_nack),
    .i_res_valid(res_valid), .i_res_rdata(res_rdata), .i_res_nack(res_nack),
    .o_busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Emulated master: check the presented command, stall, accept, answer later.
  task automatic serve_cmd(input logic [1:0] op, input logic [7:0] wd, input logic rn,
                           input logic [7:0] rd, input logic nk, input int stall);
    int n;
    n = 0;
    while (!cmd_valid && n < 50) begin
      tick();
      n++;
    end
    chk("cmd_valid", cmd_valid, 1);
    if (!cmd_valid) return;
    for (int i = 0; i < stall; i++) begin
      chk("cmd_op", cmd_op, op);
      chk("cmd_wdata", cmd_wdata, wd);
      chk("cmd_rd_nack", cmd_rd_nack, rn);
      chk("req_ready_busy", req_ready, 0);
      // stray result with nothing outstanding must be ignored
      res_valid = ($urandom_range(0, 3) == 0);
      res_nack  = 1'b1;
      res_rdata = 8'($urandom);
      tick();
      res_valid = 1'b0;
      res_nack  = 1'b0;
    end
    chk("cmd_op", cmd_op, op);
    chk("cmd_wdata", cmd_wdata, wd);
    chk("cmd_rd_nack", cmd_rd_nack, rn);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("cmd_drop", cmd_valid, 0);
    repeat ($urandom_range(0, 2)) tick();
    res_valid = 1'b1;
    res_rdata = rd;
    res_nack  = nk;
    tick();
    res_valid = 1'b0;
    res_nack  = 1'b0;
  endtask

  // Reference: build the full command list from the request, then apply any NACK abort.
  task automatic run_txn(input logic rnw, input logic [6:0] dev, input logic [8*RAB-1:0] ra,
                         input logic [8*DB-1:0] wd, input int nack_sel,
                         input logic [8*DB-1:0] rd, input int stall, input int hold);
    logic [1:0] q_op[$];
    logic [7:0] q_wd[$];
    logic       q_rn[$];
    logic [8*DB-1:0] exp_rdata;
    logic       exp_nack;
    int         k, nw, rdi, n;
    logic [7:0] rbyte;
    logic       nk;

    q_op.push_back(OP_START); q_wd.push_back(8'h00); q_rn.push_back(1'b0);
    q_op.push_back(OP_WRITE); q_wd.push_back({dev, 1'b0}); q_rn.push_back(1'b0);
    for (int i = 0; i < RAB; i++) begin
      q_op.push_back(OP_WRITE); q_wd.push_back(ra[8*(RAB-1-i) +: 8]); q_rn.push_back(1'b0);
    end
    if (!rnw) begin
      for (int i = 0; i < DB; i++) begin
        q_op.push_back(OP_WRITE); q_wd.push_back(wd[8*(DB-1-i) +: 8]); q_rn.push_back(1'b0);
      end
    end else begin
      q_op.push_back(OP_START); q_wd.push_back(8'h00); q_rn.push_back(1'b0);
      q_op.push_back(OP_WRITE); q_wd.push_back({dev, 1'b1}); q_rn.push_back(1'b0);
      for (int i = 0; i < DB; i++) begin
        q_op.push_back(OP_READ); q_wd.push_back(8'h00); q_rn.push_back(i == DB - 1);
      end
    end
    q_op.push_back(OP_STOP); q_wd.push_back(8'h00); q_rn.push_back(1'b0);
    exp_rdata = rnw ? rd : '0;
    exp_nack  = 1'b0;

    k = -1;
    if (nack_sel >= 0) begin
      nw = 0;
      for (int i = 0; i < q_op.size(); i++) begin
        if (q_op[i] == OP_WRITE) begin
          if (nw == nack_sel && k < 0) k = i;
          nw++;
        end
      end
      if (k >= 0) begin
        while (q_op.size() > k + 1) begin
          void'(q_op.pop_back()); void'(q_wd.pop_back()); void'(q_rn.pop_back());
        end
        q_op.push_back(OP_STOP); q_wd.push_back(8'h00); q_rn.push_back(1'b0);
        exp_rdata = '0;
        exp_nack  = 1'b1;
      end
    end

    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_rnw = rnw; req_dev = dev; req_reg = ra; req_wdata = wd;
    tick();
    req_valid = 1'b0;
    chk("busy_after_req", busy, 1);
    chk("first_cmd_latency", cmd_valid, 1);

    rdi = 0;
    for (int i = 0; i < q_op.size(); i++) begin
      rbyte = 8'($urandom);
      nk    = (q_op[i] != OP_WRITE) ? 1'($urandom) : 1'b0;
      if (q_op[i] == OP_READ) begin
        rbyte = rd[8*(DB-1-rdi) +: 8];
        rdi++;
      end
      if (i == k) nk = 1'b1;
      serve_cmd(q_op[i], q_wd[i], q_rn[i], rbyte, nk, (stall < 0) ? $urandom_range(0, 3) : stall);
    end

    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("no_extra_cmd", cmd_valid, 0);
    for (int i = 0; i < hold; i++) begin
      chk("rsp_hold_valid", rsp_valid, 1);
      chk("rsp_hold_ready", req_ready, 0);
      tick();
    end
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    chk("rsp_nack", rsp_nack, exp_nack);
    chk("req_ready_in_rsp", req_ready, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_done", rsp_valid, 0);
    chk("busy_done", busy, 0);
    chk("req_ready_back", req_ready, 1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_rnw = 1'b0; req_dev = '0; req_reg = '0; req_wdata = '0;
    rsp_ready = 1'b0; cmd_ready = 1'b0; res_valid = 1'b0; res_rdata = '0; res_nack = 1'b0;
    repeat (3) tick();
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    chk("idle_req_ready", req_ready, 1);

    run_txn(1'b0, 7'h50, 16'h0010, 16'h00A5, -1, 16'h0000, 0, 0);
    run_txn(1'b1, 7'h50, 16'h1234, 16'h0000, -1, 16'hBEEF, 0, 0);
    run_txn(1'b0, 7'h50, 16'h0010, 16'h00A5, 0, 16'h0000, 0, 0);
    run_txn(1'b1, 7'h2C, 16'hA55A, 16'h0000, 0, 16'h1111, 1, 2);
    run_txn(1'b1, 7'h33, 16'h0102, 16'h0000, 3, 16'h2222, -1, 1);
    run_txn(1'b0, 7'h11, 16'h0304, 16'hCAFE, 4, 16'h0000, -1, 0);
    run_txn(1'b1, 7'h50, 16'h0010, 16'h0000, -1, 16'h3C5A, 10, 5);

    for (int t = 0; t < 30; t++) begin
      logic rnw_r;
      int   nsel;
      rnw_r = 1'($urandom);
      nsel  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, rnw_r ? RAB + 1 : RAB + DB) : -1;
      run_txn(rnw_r, 7'($urandom), 16'($urandom), 16'($urandom), nsel, 16'($urandom), -1,
              $urandom_range(0, 3));
    end

    // Reset while register-address bytes are being sent.
    req_valid = 1'b1; req_rnw = 1'b1; req_dev = 7'h50; req_reg = 16'h1234; req_wdata = '0;
    tick();
    req_valid = 1'b0;
    serve_cmd(OP_START, 8'h00, 1'b0, 8'h00, 1'b0, 0);
    serve_cmd(OP_WRITE, 8'hA0, 1'b0, 8'h00, 1'b0, 0);
    chk("reg_cmd_op", cmd_op, OP_WRITE);
    chk("reg_cmd_wdata", cmd_wdata, 8'h12);
    rst = 1'b1;
    tick();
    chk("midrst_cmd_valid", cmd_valid, 0);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;
    tick();
    chk("midrst_req_ready", req_ready, 1);
    run_txn(1'b1, 7'h50, 16'h1234, 16'h0000, -1, 16'hBEEF, -1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
